// File: rtl/wide_add_seq_pkg.sv
// Shared constants and FSM encoding for the multi-word sequential adder.
package wide_add_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_seq_rca.sv
// Ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module rca #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < W; g++) begin : g_fa
    assign sum[g]  = a[g] ^ b[g] ^ c[g];
    assign c[g+1]  = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end

  assign cout = c[W];

endmodule

// File: rtl/wide_add_seq.sv
// Word-serial wide adder: operands stream in LSW first, one word per cycle,
// carry kept between words; result words come out one cycle after each accept.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cin,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_word,
  input  logic [W-1:0] b_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum_word,
  output logic         last,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  state_t        state, state_nxt;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rsum;
  logic          rcout;
  logic          accept;
  logic          is_last;
  logic          take;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_last  = (cnt == LAST_CNT);
  assign take     = out_valid && out_ready;
  assign busy     = (state != IDLE);

  rca #(.W(W)) u_rca (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry),
    .sum  (rsum),
    .cout (rcout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: start only from IDLE, so a start coinciding with the
  // DRAIN->IDLE step lands on the following cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)                state_nxt = RUN;
      RUN:     if (accept && is_last)    state_nxt = DRAIN;
      DRAIN:   if (take && last)         state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Carry and word counter: loaded on start, advanced on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      carry <= cin;
      cnt   <= '0;
    end else if (accept) begin
      carry <= rcout;
      cnt   <= cnt + 1'b1;
    end
  end

  // Output register: loads on accept, clears when taken, holds while stalled.
  // Overflow uses the carry into the MSB, recovered from a^b^sum at bit W-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_word  <= '0;
      last      <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      sum_word  <= rsum;
      last      <= is_last;
      cout      <= is_last & rcout;
      ovf       <= is_last & (a_word[W-1] ^ b_word[W-1] ^ rsum[W-1] ^ rcout);
    end else if (take) begin
      out_valid <= 1'b0;
      last      <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end
  end

endmodule
